icache_2way_rd: RTL and testbench
=================================

Name: icache_2way_rd

Overview:
- Parametrised read-only instruction cache, successor of the 8-line direct-mapped read cache.
- 2-way set-associative, 2^SET_W sets, four 32-bit words per line, 128-bit line refill from memory.
- Adds true-LRU replacement per set and a whole-cache flush input.
- Sits between the processor fetch port and the instruction memory; it never writes memory.

Parameters:
- ADDR_W, 30, processor word-address width.
- SET_W, 2, set-index width (2^SET_W sets, 2 ways each). Legal range 1..6.
- TAG_W = ADDR_W-2-SET_W, derived local parameter, tag width.

Ports:
- clk  in  1  clock; everything is rising-edge.
- proc_reset  in  1  asynchronous, active-high reset.
- proc_read  in  1  fetch request, level.
- proc_flush  in  1  invalidate all lines, single-cycle pulse.
- proc_addr  in  ADDR_W  word address: [1:0] word offset, [SET_W+1:2] set, [ADDR_W-1:SET_W+2] tag.
- proc_rdata  out  32  fetched word; valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  combinational; processor holds proc_read and proc_addr while it is 1.
- mem_read  out  1  registered line-fetch request.
- mem_addr  out  ADDR_W-2  registered line address (proc_addr[ADDR_W-1:2]).
- mem_rdata  in  128  refill line; word k occupies bits [32k+31:32k].
- mem_ready  in  1  one-cycle pulse; mem_rdata is valid in that cycle.

Behaviour:
- Storage per set: 2 × {valid, tag[TAG_W], data[128]} plus one LRU bit. LRU bit = index of the least-recently-used way.
- Reset (asynchronous, active-high):
  - All valid and LRU bits clear; state IDLE; flush_pend=0; mem_read=0; mem_addr=0.
  - proc_stall forced to 0 and proc_rdata to 0 while proc_reset=1.
  - Reset during MISS aborts the refill; mem_read drops immediately; any later mem_ready is ignored.
- IDLE:
  - Hit: proc_read=1 and some way w has valid=1 and a matching tag.
  - On hit, same cycle: proc_stall=0 and proc_rdata = data[w] word at proc_addr[1:0]. LRU[set] becomes ~w at the edge.
  - On miss: proc_stall=1 in the same cycle. At the edge: state becomes MISS, mem_read=1, mem_addr=proc_addr[ADDR_W-1:2], the victim way is latched, set is latched.
  - Victim selection: way0 if invalid, else way1 if invalid, else LRU[set].
  - proc_read=0: proc_stall=0, proc_rdata=0, no state change.
  - proc_flush=1 has priority over proc_read. proc_stall=1 that cycle. At the edge all valid bits clear and all LRU bits clear. The read is re-evaluated next cycle, so it now misses.
  - mem_ready in IDLE is ignored.
- MISS:
  - proc_stall=1 until refill. mem_read and mem_addr are held stable until mem_ready.
  - In the mem_ready cycle:
    - proc_stall=0 and proc_rdata = the mem_rdata word at proc_addr[1:0] (bypass, zero extra latency).
    - At the edge: victim way gets tag, data and valid=1; LRU[set] becomes ~victim; mem_read=0; mem_addr=0; state returns to IDLE.
  - proc_flush in MISS sets flush_pend. The refill completes and the word is still returned. At the same edge that writes the fill, all valids and LRUs clear (the flush wins over the fill) and flush_pend clears.
- Miss penalty: request registered 1 cycle after the miss is seen; total stall = 1 + memory latency cycles.
- proc_addr change during a stall is a protocol violation; behaviour is undefined.

Test Plan:
- Cold miss: reset, then read proc_addr=0x0000005. Required: proc_stall=1; next cycle mem_read=1, mem_addr=0x0000001. After 3 cycles, mem_ready with mem_rdata={0xDDDDDDDD,0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA}. Required: proc_rdata=0xBBBBBBBB, stall drops that cycle, mem_read=0 next cycle.
- Hit: after the cold miss, read 0x0000007. Required: proc_stall=0, proc_rdata=0xDDDDDDDD, mem_read stays 0.
- Conflict/LRU: fill A=0x005 and B=0x045 (both set 1), then read A (hit), then C=0x085. Required: C evicts B, mem_addr=0x021. A then hits, B misses with mem_addr=0x011.
- Flush in IDLE: after the LRU test, pulse proc_flush with proc_read on A. Required: stall that cycle; next cycle A misses with mem_read=1.
- Flush during MISS: pulse proc_flush while waiting for mem_ready. Required: word returned on mem_ready; the next read of the same address misses.
- Async reset mid-refill: assert proc_reset between the mem_read rise and mem_ready. Required: mem_read=0 without waiting for a clock edge; a late mem_ready causes no fill; the first read after reset misses.

Source files
------------

// File: rtl/icache_2way_rd.sv
// icache_2way_rd: read-only 2-way set-associative instruction cache.
// Each line holds four 32-bit words. Replacement is true LRU per set, and
// proc_flush invalidates every line. Refill data is bypassed to the processor
// in the same cycle that mem_ready arrives.
module icache_2way_rd #(
  parameter int ADDR_W = 30,
  parameter int SET_W  = 2
) (
  input  logic                clk,
  input  logic                proc_reset,
  input  logic                proc_read,
  input  logic                proc_flush,
  input  logic [ADDR_W-1:0]   proc_addr,
  output logic [31:0]         proc_rdata,
  output logic                proc_stall,
  output logic                mem_read,
  output logic [ADDR_W-3:0]   mem_addr,
  input  logic [127:0]        mem_rdata,
  input  logic                mem_ready
);

  localparam int TAG_W = ADDR_W - 2 - SET_W;
  localparam int SETS  = 1 << SET_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t              r_state;
  logic                r_valid [2][SETS];
  logic [TAG_W-1:0]    r_tag   [2][SETS];
  logic [127:0]        r_data  [2][SETS];
  logic                r_lru   [SETS];
  logic                r_flushPend;
  logic                r_victim;
  logic [SET_W-1:0]    r_set;
  logic                r_memRead;
  logic [ADDR_W-3:0]   r_memAddr;

  logic [SET_W-1:0]    w_set;
  logic [TAG_W-1:0]    w_tag;
  logic [6:0]          w_wordBit;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hitWay;
  logic                w_victim;
  logic [127:0]        w_hitLine;
  logic [31:0]         w_hitWord;
  logic [31:0]         w_fillWord;

  assign w_set      = proc_addr[SET_W+1:2];
  assign w_tag      = proc_addr[ADDR_W-1:SET_W+2];
  assign w_wordBit  = {proc_addr[1:0], 5'b00000};
  assign w_hit0     = r_valid[0][w_set] && (r_tag[0][w_set] == w_tag);
  assign w_hit1     = r_valid[1][w_set] && (r_tag[1][w_set] == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  assign w_hitWay   = !w_hit0;
  assign w_victim   = !r_valid[0][w_set] ? 1'b0 :
                      !r_valid[1][w_set] ? 1'b1 : r_lru[w_set];
  assign w_hitLine  = w_hitWay ? r_data[1][w_set] : r_data[0][w_set];
  assign w_hitWord  = w_hitLine[w_wordBit +: 32];
  assign w_fillWord = mem_rdata[w_wordBit +: 32];

  assign mem_read = r_memRead;
  assign mem_addr = r_memAddr;

  // Processor-facing response: hit data, refill bypass, or stall.
  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = '0;
    if (!proc_reset) begin
      case (r_state)
        IDLE: begin
          if (proc_flush) begin
            proc_stall = 1'b1;
          end else if (proc_read) begin
            if (w_hit) proc_rdata = w_hitWord;
            else       proc_stall = 1'b1;
          end
        end
        MISS: begin
          if (mem_ready) proc_rdata = w_fillWord;
          else           proc_stall = 1'b1;
        end
        default: proc_stall = 1'b0;
      endcase
    end
  end

  // Control FSM: valid/LRU bookkeeping, miss request and deferred flush.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state     <= IDLE;
      r_flushPend <= 1'b0;
      r_victim    <= 1'b0;
      r_set       <= '0;
      r_memRead   <= 1'b0;
      r_memAddr   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[0][s] <= 1'b0;
        r_valid[1][s] <= 1'b0;
        r_lru[s]      <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (proc_flush) begin
            for (int s = 0; s < SETS; s++) begin
              r_valid[0][s] <= 1'b0;
              r_valid[1][s] <= 1'b0;
              r_lru[s]      <= 1'b0;
            end
          end else if (proc_read) begin
            if (w_hit) begin
              r_lru[w_set] <= ~w_hitWay;
            end else begin
              r_state   <= MISS;
              r_memRead <= 1'b1;
              r_memAddr <= proc_addr[ADDR_W-1:2];
              r_victim  <= w_victim;
              r_set     <= w_set;
            end
          end
        end
        MISS: begin
          if (proc_flush) r_flushPend <= 1'b1;
          if (mem_ready) begin
            r_valid[r_victim][r_set] <= 1'b1;
            r_lru[r_set]             <= ~r_victim;
            r_memRead                <= 1'b0;
            r_memAddr                <= '0;
            r_state                  <= IDLE;
            r_flushPend              <= 1'b0;
            if (r_flushPend || proc_flush) begin
              for (int s = 0; s < SETS; s++) begin
                r_valid[0][s] <= 1'b0;
                r_valid[1][s] <= 1'b0;
                r_lru[s]      <= 1'b0;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data storage is written only by a completing refill.
  always_ff @(posedge clk) begin
    if ((r_state == MISS) && mem_ready) begin
      r_tag[r_victim][r_set]  <= r_memAddr[ADDR_W-3:SET_W];
      r_data[r_victim][r_set] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_2way_rd.sv
// tb_icache_2way_rd: randomized scoreboard bench for icache_2way_rd.
// A per-set recency model predicts hits and misses; a monitor pops expected
// fetch words whenever the cache presents an unstalled read.
module tb_icache_2way_rd;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_flush = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ [$];
  logic [31:0] monExp;

  bit mValid [4][2];
  int mTag   [4][2];
  int mUse   [4][2];
  int tick = 0;

  icache_2way_rd #(.ADDR_W(30), .SET_W(2)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read),
    .proc_flush(proc_flush), .proc_addr(proc_addr), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic logic [127:0] memLine(input logic [27:0] line);
    logic [127:0] l;
    if (line == 28'd1) return {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    for (int k = 0; k < 4; k++)
      l[32*k +: 32] = (32'(line) * 32'h9E3779B1) + (32'(k) * 32'h01000193) + 32'h1234;
    return l;
  endfunction

  function automatic logic [31:0] memWord(input logic [29:0] addr);
    logic [127:0] l;
    l = memLine(addr[29:2]);
    return l[32*addr[1:0] +: 32];
  endfunction

  function automatic bit modelHit(input logic [29:0] addr);
    int s = int'(addr[3:2]);
    int t = int'(addr[29:4]);
    return (mValid[s][0] && mTag[s][0] == t) || (mValid[s][1] && mTag[s][1] == t);
  endfunction

  task automatic modelTouch(input logic [29:0] addr);
    int s = int'(addr[3:2]);
    int t = int'(addr[29:4]);
    tick++;
    if (mValid[s][0] && mTag[s][0] == t) mUse[s][0] = tick;
    else                                 mUse[s][1] = tick;
  endtask

  task automatic modelFill(input logic [29:0] addr);
    int s = int'(addr[3:2]);
    int w;
    if (!mValid[s][0])      w = 0;
    else if (!mValid[s][1]) w = 1;
    else                    w = (mUse[s][0] < mUse[s][1]) ? 0 : 1;
    tick++;
    mValid[s][w] = 1'b1;
    mTag[s][w]   = int'(addr[29:4]);
    mUse[s][w]   = tick;
  endtask

  task automatic modelFlush();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        mValid[s][w] = 1'b0;
        mUse[s][w]   = 0;
      end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every unstalled read must match the next expected word.
  always @(negedge clk) begin
    if (!proc_reset && proc_read && !proc_stall) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWord: got %h expected none", proc_rdata);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("rdata", proc_rdata, monExp);
      end
    end
  end

  // One fetch; expMissIn 0/1 forces the expectation, 2 asks the model.
  task automatic applyStimulus(input logic [29:0] addr, input int lat,
                               input bit flushInMiss, input int expMissIn);
    bit miss;
    logic [27:0] line;
    line = addr[29:2];
    miss = (expMissIn == 2) ? !modelHit(addr) : (expMissIn != 0);
    proc_read = 1'b1;
    proc_addr = addr;
    expQ.push_back(memWord(addr));
    @(negedge clk);
    checkOutput("stallFirst", {31'b0, proc_stall}, {31'b0, miss});
    if (!miss) begin
      checkOutput("hitNoMemRead", {31'b0, mem_read}, 32'd0);
      modelTouch(addr);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      if (flushInMiss) proc_flush = 1'b1;
      checkOutput("memRead", {31'b0, mem_read}, 32'd1);
      checkOutput("memAddr", {4'b0, mem_addr}, {4'b0, line});
      for (int i = 1; i < lat; i++) begin
        @(negedge clk);
        checkOutput("stallWait", {31'b0, proc_stall}, 32'd1);
        @(posedge clk); #1;
        proc_flush = 1'b0;
        checkOutput("memAddrHold", {4'b0, mem_addr}, {4'b0, line});
      end
      mem_ready = 1'b1;
      mem_rdata = memLine(line);
      @(posedge clk); #1;
      mem_ready  = 1'b0;
      mem_rdata  = '0;
      proc_flush = 1'b0;
      checkOutput("memReadDrop", {31'b0, mem_read}, 32'd0);
      modelFill(addr);
      if (flushInMiss) modelFlush();
    end
    proc_read = 1'b0;
  endtask

  // Flush pulse while a read is pending; the read stays asserted afterwards.
  task automatic flushIdle(input logic [29:0] addr);
    proc_read  = 1'b1;
    proc_addr  = addr;
    proc_flush = 1'b1;
    @(negedge clk);
    checkOutput("flushStall", {31'b0, proc_stall}, 32'd1);
    @(posedge clk); #1;
    proc_flush = 1'b0;
    modelFlush();
  endtask

  // Reset asserted between mem_read rising and mem_ready.
  task automatic resetMidRefill(input logic [29:0] addr);
    proc_read = 1'b1;
    proc_addr = addr;
    @(negedge clk);
    checkOutput("rstMissStall", {31'b0, proc_stall}, {31'b0, !modelHit(addr)});
    @(posedge clk); #1;
    checkOutput("rstMemReadUp", {31'b0, mem_read}, 32'd1);
    #2;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    #1;
    checkOutput("rstAbortMemRead", {31'b0, mem_read}, 32'd0);
    checkOutput("rstAbortMemAddr", {4'b0, mem_addr}, 32'd0);
    modelFlush();
    @(posedge clk); #1;
    proc_reset = 1'b0;
    mem_ready  = 1'b1;
    mem_rdata  = ~memLine(addr[29:2]);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("lateReadyIgnored", {31'b0, mem_read}, 32'd0);
    applyStimulus(addr, 2, 1'b0, 1);
  endtask

  // Bound on total run time.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [29:0] a;
    int lat;
    modelFlush();
    proc_reset = 1'b1;
    proc_read  = 1'b1;
    proc_addr  = 30'h5;
    #3;
    checkOutput("rstStall", {31'b0, proc_stall}, 32'd0);
    checkOutput("rstRdata", proc_rdata, 32'd0);
    checkOutput("rstMemRead", {31'b0, mem_read}, 32'd0);
    checkOutput("rstMemAddr", {4'b0, mem_addr}, 32'd0);
    @(posedge clk); #1;
    proc_reset = 1'b0;
    proc_read  = 1'b0;
    @(posedge clk); #1;

    applyStimulus(30'h005, 3, 1'b0, 1);
    applyStimulus(30'h007, 1, 1'b0, 0);
    applyStimulus(30'h045, 2, 1'b0, 1);
    applyStimulus(30'h005, 1, 1'b0, 0);
    applyStimulus(30'h085, 2, 1'b0, 1);
    applyStimulus(30'h005, 1, 1'b0, 0);
    applyStimulus(30'h045, 2, 1'b0, 1);

    flushIdle(30'h005);
    applyStimulus(30'h005, 2, 1'b0, 1);

    applyStimulus(30'h009, 3, 1'b1, 1);
    applyStimulus(30'h009, 2, 1'b0, 1);

    resetMidRefill(30'h00D);

    for (int n = 0; n < 60; n++) begin
      a = 30'(($urandom_range(0, 2) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      lat = $urandom_range(1, 4);
      case ($urandom_range(0, 11))
        0: begin
          flushIdle(a);
          applyStimulus(a, lat, 1'b0, 2);
        end
        1: begin
          mem_ready = 1'b1;
          mem_rdata = {4{32'hBAD0BAD0}};
          @(negedge clk);
          checkOutput("idleReadyStall", {31'b0, proc_stall}, 32'd0);
          @(posedge clk); #1;
          mem_ready = 1'b0;
          mem_rdata = '0;
          applyStimulus(a, lat, 1'b0, 2);
        end
        2: applyStimulus(a, lat, 1'b1, 2);
        default: applyStimulus(a, lat, 1'b0, 2);
      endcase
    end

    @(posedge clk); #1;
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
